// File: rtl/hopfield_pkg.sv
// Shared constants, FSM state type and power-on contents for the Hopfield sequencer.
package hopfield_pkg;

   localparam int N_NEUR  = 25;
   localparam int N_LINKS = 625;
   localparam int W_BITS  = 4;
   localparam int S_BITS  = 8;
   localparam int A_BITS  = 10;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LEARN,
      ST_R_FETCH,
      ST_R_MAC,
      ST_R_WB,
      ST_R_CHECK
   } hop_state_t;

   localparam logic [N_NEUR-1:0] PAT_DEF0 = 25'b0111010010100101001001111;
   localparam logic [N_NEUR-1:0] PAT_DEF1 = 25'b0011101001010000100011111;
   localparam logic [N_NEUR-1:0] PAT_DEF2 = 25'b1111000001000010000111110;
   localparam logic [N_NEUR-1:0] PAT_DEF3 = 25'b1000110001101011101110001;
   localparam logic [N_NEUR-1:0] NEUR_RST = 25'b0111010011100100001001110;

   // Power-on contents of pattern slot idx.
   function automatic logic [N_NEUR-1:0] pat_default(input int idx);
      case (idx)
         0:       return PAT_DEF0;
         1:       return PAT_DEF1;
         2:       return PAT_DEF2;
         default: return PAT_DEF3;
      endcase
   endfunction

   // Link address 25k+m built from shifts and adds so no multiplier is inferred.
   function automatic logic [A_BITS-1:0] link_addr(input logic [4:0] k, input logic [4:0] m);
      logic [A_BITS-1:0] kx;
      kx = {5'b00000, k};
      return (kx << 4) + (kx << 3) + kx + {5'b00000, m};
   endfunction

endpackage

// File: rtl/hopfield_sequencer_link_ram.sv
// 625 x 4-bit single-port weight store, synchronous write, registered read.
module link_ram import hopfield_pkg::*; (
   input  logic              clk,
   input  logic              i_we,
   input  logic [A_BITS-1:0] i_addr,
   input  logic [W_BITS-1:0] i_wdata,
   output logic [W_BITS-1:0] o_rdata
);

   logic [W_BITS-1:0] r_mem [0:N_LINKS-1];
   logic [W_BITS-1:0] r_rdata;

   // Write port and one-cycle registered read so the array maps to block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/hopfield_sequencer.sv
// Time-shared Hebbian learn and asynchronous recall controller for the 5x5 matrix.
module hopfield_sequencer import hopfield_pkg::*; #(
   parameter int N          = 25,
   parameter int P          = 4,
   parameter int MAX_SWEEPS = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_pat_we,
   input  logic [1:0]   i_pat_idx,
   input  logic [N-1:0] i_pat_data,
   input  logic         i_state_we,
   input  logic [N-1:0] i_state_data,
   input  logic         i_learn_req,
   input  logic         i_recall_req,
   output logic         o_busy,
   output logic         o_done,
   output logic         o_converged,
   output logic [3:0]   o_sweeps,
   output logic         o_learned,
   output logic [N-1:0] o_neurons
);

   hop_state_t               r_state;
   logic                     r_busy;
   logic                     r_done;
   logic                     r_conv;
   logic [3:0]               r_sweeps;
   logic                     r_learned;
   logic                     r_changed;
   logic [4:0]               r_k;
   logic [4:0]               r_m;
   logic signed [S_BITS-1:0] r_sum;
   logic [N_NEUR-1:0]        r_neurons;
   logic [N_NEUR-1:0]        r_pat [0:P-1];

   logic [P-1:0]             w_agree_bits;
   logic [2:0]               w_agree;
   logic [W_BITS-1:0]        w_weight;
   logic [W_BITS-1:0]        w_ram_rdata;
   logic signed [S_BITS-1:0] w_w_ext;
   logic signed [S_BITS-1:0] w_term;
   logic [4:0]               w_rd_m;
   logic [A_BITS-1:0]        w_addr;
   logic                     w_ram_we;
   logic                     w_new_bit;
   logic [3:0]               w_sweeps_inc;

   // One agreement bit per stored pattern for the current (k,m) link.
   genvar gi;
   generate
      for (gi = 0; gi < P; gi++) begin : g_agree
         assign w_agree_bits[gi] = (r_pat[gi][r_k] == r_pat[gi][r_m]);
      end
   endgenerate

   // Hebbian weight: agreements count +1, disagreements -1, i.e. 2*agree - P.
   always_comb begin
      w_agree = 3'd0;
      for (int p = 0; p < P; p++) begin
         w_agree = w_agree + {2'b00, w_agree_bits[p]};
      end
      w_weight = {w_agree, 1'b0} - 4'(P);
   end

   // During MAC the RAM is addressed one link ahead to hide its read latency.
   always_comb begin
      w_rd_m = r_m;
      if (r_state == ST_R_MAC && r_m != 5'd24) begin
         w_rd_m = r_m + 5'd1;
      end
   end

   assign w_addr       = link_addr(r_k, w_rd_m);
   assign w_ram_we     = (r_state == ST_LEARN);
   assign w_w_ext      = {{(S_BITS-W_BITS){w_ram_rdata[W_BITS-1]}}, w_ram_rdata};
   assign w_term       = r_neurons[r_m] ? w_w_ext : -w_w_ext;
   assign w_new_bit    = (r_sum > 8'sd0);
   assign w_sweeps_inc = r_sweeps + 4'd1;

   link_ram u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_addr),
      .i_wdata (w_weight),
      .o_rdata (w_ram_rdata)
   );

   // Sequencer FSM: learn sweep over all links, then neuron-by-neuron recall sweeps.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= ST_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_conv    <= 1'b0;
         r_sweeps  <= 4'd0;
         r_learned <= 1'b0;
         r_changed <= 1'b0;
         r_k       <= 5'd0;
         r_m       <= 5'd0;
         r_sum     <= '0;
         r_neurons <= NEUR_RST;
         for (int p = 0; p < P; p++) begin
            r_pat[p] <= pat_default(p);
         end
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_pat_we) begin
                  r_pat[i_pat_idx] <= i_pat_data;
               end
               if (i_state_we) begin
                  r_neurons <= i_state_data;
               end
               if (i_learn_req) begin
                  r_state   <= ST_LEARN;
                  r_busy    <= 1'b1;
                  r_learned <= 1'b0;
                  r_conv    <= 1'b0;
                  r_k       <= 5'd0;
                  r_m       <= 5'd0;
               end else if (i_recall_req && r_learned) begin
                  r_state   <= ST_R_FETCH;
                  r_busy    <= 1'b1;
                  r_conv    <= 1'b0;
                  r_sweeps  <= 4'd0;
                  r_changed <= 1'b0;
                  r_k       <= 5'd0;
                  r_m       <= 5'd0;
               end
            end
            ST_LEARN: begin
               if (r_m == 5'd24) begin
                  r_m <= 5'd0;
                  if (r_k == 5'd24) begin
                     r_state   <= ST_IDLE;
                     r_busy    <= 1'b0;
                     r_done    <= 1'b1;
                     r_learned <= 1'b1;
                  end else begin
                     r_k <= r_k + 5'd1;
                  end
               end else begin
                  r_m <= r_m + 5'd1;
               end
            end
            ST_R_FETCH: begin
               r_sum   <= '0;
               r_m     <= 5'd0;
               r_state <= ST_R_MAC;
            end
            ST_R_MAC: begin
               r_sum <= r_sum + w_term;
               if (r_m == 5'd24) begin
                  r_state <= ST_R_WB;
               end else begin
                  r_m <= r_m + 5'd1;
               end
            end
            ST_R_WB: begin
               r_neurons[r_k] <= w_new_bit;
               if (w_new_bit != r_neurons[r_k]) begin
                  r_changed <= 1'b1;
               end
               r_m <= 5'd0;
               if (r_k == 5'd24) begin
                  r_state <= ST_R_CHECK;
               end else begin
                  r_k     <= r_k + 5'd1;
                  r_state <= ST_R_FETCH;
               end
            end
            ST_R_CHECK: begin
               r_sweeps <= w_sweeps_inc;
               if (!r_changed) begin
                  r_conv  <= 1'b1;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else if (w_sweeps_inc == 4'(MAX_SWEEPS)) begin
                  r_conv  <= 1'b0;
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end else begin
                  r_changed <= 1'b0;
                  r_k       <= 5'd0;
                  r_state   <= ST_R_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy      = r_busy;
   assign o_done      = r_done;
   assign o_converged = r_conv;
   assign o_sweeps    = r_sweeps;
   assign o_learned   = r_learned;
   assign o_neurons   = r_neurons;

endmodule

// File: tb/tb_hopfield_sequencer.sv
// Self-checking bench for hopfield_sequencer: directed table, corner sequences, random vs model.
module tb_hopfield_sequencer;

   localparam logic [24:0] RST_NEUR = 25'b0111010011100100001001110;
   localparam logic [24:0] DEF0     = 25'b0111010010100101001001111;
   localparam logic [24:0] DEF1     = 25'b0011101001010000100011111;
   localparam logic [24:0] DEF2     = 25'b1111000001000010000111110;
   localparam logic [24:0] DEF3     = 25'b1000110001101011101110001;
   localparam logic [24:0] PD       = 25'b1010110011100011010110101;
   localparam int          SWEEP_CY = 676;
   localparam int          MAXSW    = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        i_pat_we = 1'b0;
   logic [1:0]  i_pat_idx = 2'd0;
   logic [24:0] i_pat_data = '0;
   logic        i_state_we = 1'b0;
   logic [24:0] i_state_data = '0;
   logic        i_learn_req = 1'b0;
   logic        i_recall_req = 1'b0;
   logic        o_busy;
   logic        o_done;
   logic        o_converged;
   logic [3:0]  o_sweeps;
   logic        o_learned;
   logic [24:0] o_neurons;

   int n_cmp  = 0;
   int n_fail = 0;

   logic [24:0] mp [4];
   int          mw [25][25];

   typedef struct {
      logic [24:0] init;
      logic [24:0] exp_n;
      int          exp_sw;
      bit          exp_conv;
   } rcase_t;

   rcase_t tbl [4];

   always #5 clk = ~clk;

   hopfield_sequencer #(.N(25), .P(4), .MAX_SWEEPS(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .i_pat_we     (i_pat_we),
      .i_pat_idx    (i_pat_idx),
      .i_pat_data   (i_pat_data),
      .i_state_we   (i_state_we),
      .i_state_data (i_state_data),
      .i_learn_req  (i_learn_req),
      .i_recall_req (i_recall_req),
      .o_busy       (o_busy),
      .o_done       (o_done),
      .o_converged  (o_converged),
      .o_sweeps     (o_sweeps),
      .o_learned    (o_learned),
      .o_neurons    (o_neurons)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Weight table straight from the Hebbian rule.
   task automatic model_learn();
      for (int k = 0; k < 25; k++) begin
         for (int m = 0; m < 25; m++) begin
            int s;
            s = 0;
            for (int p = 0; p < 4; p++) s += (mp[p][k] == mp[p][m]) ? 1 : -1;
            mw[k][m] = s;
         end
      end
   endtask

   // In-place sequential recall until a sweep changes nothing or the sweep limit is hit.
   task automatic model_recall(input logic [24:0] init, output logic [24:0] fin,
                               output int sw, output bit conv);
      logic [24:0] s;
      bit          ch;
      s    = init;
      sw   = 0;
      conv = 1'b0;
      for (int it = 0; it < MAXSW; it++) begin
         ch = 1'b0;
         for (int k = 0; k < 25; k++) begin
            int  sum;
            bit  nb;
            sum = 0;
            for (int m = 0; m < 25; m++) sum += s[m] ? mw[k][m] : -mw[k][m];
            nb = (sum > 0);
            if (nb != s[k]) ch = 1'b1;
            s[k] = nb;
         end
         sw++;
         if (!ch) begin
            conv = 1'b1;
            break;
         end
      end
      fin = s;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic write_pat(input int idx, input logic [24:0] d);
      @(negedge clk);
      i_pat_we   = 1'b1;
      i_pat_idx  = 2'(idx);
      i_pat_data = d;
      @(negedge clk);
      i_pat_we   = 1'b0;
      mp[idx]    = d;
   endtask

   task automatic load_state(input logic [24:0] d);
      @(negedge clk);
      i_state_we   = 1'b1;
      i_state_data = d;
      @(negedge clk);
      i_state_we   = 1'b0;
   endtask

   // Watch cycles after acceptance; optionally inject dropped requests/writes at cycle poke_at.
   task automatic wait_done(input int budget, input int poke_at, input logic [24:0] poke_val,
                            output int busy_cnt, output bit seen, output bit busy_at_done);
      busy_cnt     = 0;
      seen         = 1'b0;
      busy_at_done = 1'b0;
      for (int c = 1; c <= budget; c++) begin
         if (o_done) begin
            seen         = 1'b1;
            busy_at_done = o_busy;
            break;
         end
         if (o_busy) busy_cnt++;
         i_recall_req = (c == poke_at);
         i_pat_we     = (c == poke_at);
         i_state_we   = (c == poke_at);
         i_pat_idx    = 2'd0;
         i_pat_data   = poke_val;
         i_state_data = ~poke_val;
         @(negedge clk);
      end
      i_recall_req = 1'b0;
      i_pat_we     = 1'b0;
      i_state_we   = 1'b0;
   endtask

   task automatic check_ram(input string name);
      int bad;
      bad = 0;
      for (int i = 0; i < 625; i++) begin
         logic [3:0] e;
         e = 4'(mw[i / 25][i % 25]);
         if (dut.u_ram.r_mem[i] !== e) bad++;
      end
      check(name, bad, 0);
   endtask

   task automatic run_learn(input string name, input bit with_recall, input int poke_at);
      int bc;
      bit seen, bad;
      @(negedge clk);
      i_learn_req  = 1'b1;
      i_recall_req = with_recall;
      @(negedge clk);
      i_learn_req  = 1'b0;
      i_recall_req = 1'b0;
      wait_done(800, poke_at, 25'h0AAAAAA, bc, seen, bad);
      check({name, "_done_seen"}, seen, 1);
      check({name, "_busy_cycles"}, bc, 625);
      check({name, "_busy_at_done"}, bad, 0);
      check({name, "_learned"}, o_learned, 1);
      model_learn();
      check_ram({name, "_ram_table"});
      $display("learn %s: busy_cycles=%0d done=%0d learned=%0d", name, bc, seen, o_learned);
   endtask

   task automatic run_recall(input string name, input logic [24:0] init, input logic [24:0] exp_n,
                             input int exp_sw, input bit exp_conv);
      int bc;
      bit seen, bad;
      load_state(init);
      @(negedge clk);
      i_recall_req = 1'b1;
      @(negedge clk);
      i_recall_req = 1'b0;
      wait_done(MAXSW * SWEEP_CY + 50, -1, '0, bc, seen, bad);
      check({name, "_done_seen"}, seen, 1);
      check({name, "_busy_cycles"}, bc, SWEEP_CY * exp_sw);
      check({name, "_busy_at_done"}, bad, 0);
      check({name, "_neurons"}, o_neurons, exp_n);
      check({name, "_sweeps"}, o_sweeps, exp_sw);
      check({name, "_converged"}, o_converged, exp_conv);
      $display("recall %s: init=%07h neurons=%07h sweeps=%0d conv=%0d busy_cycles=%0d",
               name, init, o_neurons, o_sweeps, o_converged, bc);
   endtask

   initial begin
      int          cnt_busy, cnt_done;
      logic [24:0] en, st;
      int          es;
      bit          ec;

      tbl[0] = '{PD,                 PD,  1, 1'b1};
      tbl[1] = '{PD ^ 25'h0000080,   PD,  2, 1'b1};
      tbl[2] = '{PD ^ 25'h1001001,   PD,  2, 1'b1};
      tbl[3] = '{~PD,                ~PD, 1, 1'b1};

      mp[0] = DEF0; mp[1] = DEF1; mp[2] = DEF2; mp[3] = DEF3;

      // Reset state.
      do_reset();
      check("rst_busy", o_busy, 0);
      check("rst_done", o_done, 0);
      check("rst_converged", o_converged, 0);
      check("rst_sweeps", o_sweeps, 0);
      check("rst_learned", o_learned, 0);
      check("rst_neurons", o_neurons, RST_NEUR);
      $display("reset: neurons=%07h learned=%0d", o_neurons, o_learned);

      // Recall without a learned table is ignored.
      @(negedge clk);
      i_recall_req = 1'b1;
      @(negedge clk);
      i_recall_req = 1'b0;
      cnt_busy = 0; cnt_done = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_busy) cnt_busy++;
         if (o_done) cnt_done++;
         @(negedge clk);
      end
      check("unlearned_busy", cnt_busy, 0);
      check("unlearned_done", cnt_done, 0);
      check("unlearned_neurons", o_neurons, RST_NEUR);
      $display("recall unlearned: busy_cycles=%0d done_pulses=%0d", cnt_busy, cnt_done);

      // Learn and recall together: learn only; mid-learn recall/pat_we/state_we dropped.
      run_learn("default", 1'b1, 100);
      check("default_ram0", dut.u_ram.r_mem[0], 4'(4));
      check("default_ram1", dut.u_ram.r_mem[1], 4'(mw[0][1]));
      check("drop_slot0", dut.r_pat[0], DEF0);
      check("drop_neurons", o_neurons, RST_NEUR);
      cnt_busy = 0;
      for (int c = 0; c < 20; c++) begin
         if (o_busy) cnt_busy++;
         @(negedge clk);
      end
      check("drop_recall_busy", cnt_busy, 0);

      // All slots hold PD; directed recall table.
      for (int p = 0; p < 4; p++) write_pat(p, PD);
      run_learn("all_pd", 1'b0, -1);
      for (int i = 0; i < 4; i++) begin
         run_recall($sformatf("tbl%0d", i), tbl[i].init, tbl[i].exp_n, tbl[i].exp_sw, tbl[i].exp_conv);
      end

      // Random patterns and states against the model.
      for (int r = 0; r < 2; r++) begin
         for (int p = 0; p < 4; p++) write_pat(p, 25'($urandom()));
         run_learn($sformatf("rnd%0d", r), 1'b0, -1);
         for (int t = 0; t < 4; t++) begin
            st = 25'($urandom());
            model_recall(st, en, es, ec);
            run_recall($sformatf("rnd%0d_%0d", r, t), st, en, es, ec);
         end
      end

      // Reset in the middle of a recall.
      load_state(25'($urandom()));
      @(negedge clk);
      i_recall_req = 1'b1;
      @(negedge clk);
      i_recall_req = 1'b0;
      cnt_done = 0;
      for (int c = 1; c < 300; c++) begin
         if (o_done) cnt_done++;
         @(negedge clk);
      end
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_busy", o_busy, 0);
      check("midrst_neurons", o_neurons, RST_NEUR);
      check("midrst_learned", o_learned, 0);
      check("midrst_sweeps", o_sweeps, 0);
      check("midrst_converged", o_converged, 0);
      cnt_busy = 0;
      for (int c = 0; c < 700; c++) begin
         if (o_done) cnt_done++;
         if (o_busy) cnt_busy++;
         @(negedge clk);
      end
      check("midrst_done_pulses", cnt_done, 0);
      check("midrst_busy_after", cnt_busy, 0);
      $display("reset mid-recall: neurons=%07h done_pulses=%0d", o_neurons, cnt_done);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
